rs_encoder: RTL and testbench
=============================

# rs_encoder

Systematic Reed-Solomon RS(N,K) encoder over GF(2^5). It is the transmit-side counterpart of the RS decoder and uses the same field: primitive polynomial x^5 + x^2 + 1, α = 5'b00010, and generator roots α^1..α^(N-K). The block accepts K message symbols over a valid/ready stream. It forwards them unchanged, then appends N-K parity symbols computed by a registered LFSR division circuit.

## Interface
Parameters:
- N, default 31: codeword length in symbols; must be ≤ 31.
- K, default 23: message length in symbols; N-K must be even and ≥ 2.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data holds a message symbol.
- in_data  input  5  message symbol; bit i is the coefficient of α^i, bit 4 is the MSB.
- in_ready  output  1  encoder accepts in_data this cycle.
- out_valid  output  1  out_data holds a codeword symbol.
- out_data  output  5  codeword symbol, same bit order as in_data.
- out_last  output  1  marks the final parity symbol of a codeword.
- out_ready  input  1  downstream accepts out_data this cycle.

## Operation
- P = N-K. LFSR state is r[0..P-1] (5 bits each). Generator coefficients g[0..P-1] are constants; g(x) is monic.
- FSM states:
  - MSG (reset state).
  - PARITY.
- MSG:
  - Input accept occurs when in_valid && in_ready.
  - On accept, out_data ← in_data.
  - The LFSR updates on the same edge:
    - fb = in_data ⊕ r[P-1].
    - r[j] ← r[j-1] ⊕ fb·g[j] for j ≥ 1.
    - r[0] ← fb·g[0].
  - sym_cnt increments on each accept. The accept at sym_cnt = K-1 moves the FSM to PARITY and clears sym_cnt.
- PARITY:
  - in_ready = 0.
  - Each time the output register can load, out_data ← r[P-1] and the LFSR shifts: r[j] ← r[j-1], r[0] ← 0.
  - The P-th parity load sets out_last = 1, clears sym_cnt and the LFSR, and returns the FSM to MSG.
- Output register "can load" when !out_valid || out_ready.
  - in_ready = (state == MSG) && (!out_valid || out_ready).
- GF arithmetic:
  - Addition is bitwise XOR.
  - Multiplication by a constant g[j] uses the decoder's parallel multiplier form, reduced with x^5 = x^2 + 1.
- Codeword symbol order: m[K-1]…m[0], then r[P-1]…r[0] (highest degree first).

## Timing
- Reset (asynchronous assert, synchronous release):
  - out_valid = 0, out_data = 0, out_last = 0.
  - in_ready = 1 after release.
  - FSM = MSG, sym_cnt = 0, all r[j] = 0.
- Latency: one cycle from input accept to the corresponding out_valid.
- Throughput: one symbol per cycle with out_ready held high.
  - N output symbols per codeword.
  - in_ready is low for the P cycles of the PARITY phase.
- Backpressure:
  - While out_valid && !out_ready, out_data and out_last hold and the LFSR does not advance, in both states.
- out_valid:
  - Set by any output-register load.
  - Cleared on out_ready when no new load occurs in that cycle.
- out_last is 1 only while the final parity symbol is held. It clears when that symbol is accepted.
- Back-to-back codewords: the first message symbol of the next codeword may be accepted in the cycle immediately after the last parity load. There is no bubble.
- Reset asserted mid-codeword:
  - The partial codeword is discarded.
  - No out_last is emitted.
  - The next codeword starts cleanly from symbol 0.
- in_valid low in MSG: no state change. Message gaps are allowed.

## Structure
- Package rs_gf5_pkg holds:
  - Symbol width 5 and symbol typedef.
  - Primitive polynomial constant.
  - Default N, K.
  - Generator coefficient table G_COEF[0..P-1] for P = 8, precomputed offline from ∏(x - α^i), i = 1..8.
  - FSM state enum.
  - A gf_mul_const function.
  - This package is shared with the decoder.
- One sub-module, rs_parity_lfsr: the P-stage register array with feedback and multipliers, plus the load/shift/clear controls. The FSM, counter and stream handshake stay in rs_encoder.

## Test plan
- All-zero message, 23 × 5'h00 → 31 output symbols all 5'h00; out_last on symbol 31 only.
- Message 22 × 5'h00 then 5'h01 → parity symbols equal G_COEF[7]…G_COEF[0] (x^8 mod g(x)).
- Linearity: random A and B, encode A, B and A⊕B → parity(A⊕B) = parity(A) ⊕ parity(B).
- Backpressure: out_ready low for 3 cycles at parity symbol 4 → out_data/out_last hold, no symbol lost or duplicated, final codeword matches the reference model.
- Reset mid-codeword: assert reset_n = 0 after 10 message symbols → all outputs read 0 immediately; the next full codeword encodes correctly.
- Loopback: 100 random messages with out_ready randomly toggled, fed to the RS decoder with 0–4 injected symbol errors → all syndromes zero when uncorrupted, decoded message equals input.

Source files
------------

// File: rtl/rs_gf5_pkg.sv
// GF(2^5) definitions shared by the Reed-Solomon encoder and decoder.
// Field: x^5 + x^2 + 1, alpha = 5'b00010, generator roots alpha^1..alpha^P.
package rs_gf5_pkg;

  localparam int unsigned SYM_W     = 5;
  localparam int unsigned N_DEFAULT = 31;
  localparam int unsigned K_DEFAULT = 23;
  localparam int unsigned P_MAX     = 8;
  localparam int unsigned P_LIM     = 30;

  typedef logic [SYM_W-1:0] sym_t;
  typedef logic [P_LIM-1:0][SYM_W-1:0] gen_t;

  localparam logic [SYM_W:0] PRIM_POLY = 6'b100101;

  // g(x) = prod (x - alpha^i), i = 1..8; index j is the coefficient of x^j (x^8 term is 1)
  localparam logic [P_MAX-1:0][SYM_W-1:0] G_COEF = {
    5'd8, 5'd21, 5'd15, 5'd6, 5'd2, 5'd26, 5'd18, 5'd5
  };

  typedef enum logic {StMsg, StParity} enc_state_e;

  function automatic sym_t gf_xtime(sym_t a);
    sym_t res;
    res = {a[SYM_W-2:0], 1'b0};
    if (a[SYM_W-1]) res = res ^ PRIM_POLY[SYM_W-1:0];
    return res;
  endfunction

  // Parallel form: XOR of c*alpha^i for every set bit i of a; folds to XOR gates for constant c.
  function automatic sym_t gf_mul_const(sym_t a, sym_t c);
    sym_t acc;
    sym_t sh;
    acc = '0;
    sh  = c;
    for (int i = 0; i < SYM_W; i++) begin
      if (a[i]) acc = acc ^ sh;
      sh = gf_xtime(sh);
    end
    return acc;
  endfunction

  // Low P coefficients of the generator; the precomputed table covers the default P.
  function automatic gen_t gen_poly(int unsigned p);
    logic [P_LIM:0][SYM_W-1:0] g;
    gen_t res;
    sym_t root;
    res = '0;
    if (p == P_MAX) begin
      res[P_MAX-1:0] = G_COEF;
    end else begin
      g    = '0;
      g[0] = sym_t'(1);
      root = sym_t'(1);
      for (int unsigned i = 1; i <= p; i++) begin
        root = gf_xtime(root);
        for (int unsigned j = i; j > 0; j--) begin
          g[j] = g[j-1] ^ gf_mul_const(g[j], root);
        end
        g[0] = gf_mul_const(g[0], root);
      end
      res = g[P_LIM-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/rs_parity_lfsr.sv
// P-stage LFSR dividing the message by g(x); also shifts out the remainder and clears.
module rs_parity_lfsr
  import rs_gf5_pkg::*;
#(
  parameter int unsigned P = 8,
  parameter logic [P-1:0][SYM_W-1:0] GEN = '0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             feed,
  input  logic             shift,
  input  logic             clear,
  input  logic [SYM_W-1:0] din,
  output logic [SYM_W-1:0] msb
);

  logic [P-1:0][SYM_W-1:0] r_q, r_d;
  sym_t fb;

  always_comb begin
    fb  = din ^ r_q[P-1];
    r_d = r_q;
    if (clear) begin
      r_d = '0;
    end else if (feed) begin
      r_d[0] = gf_mul_const(fb, GEN[0]);
      for (int unsigned j = 1; j < P; j++) begin
        r_d[j] = r_q[j-1] ^ gf_mul_const(fb, GEN[j]);
      end
    end else if (shift) begin
      r_d = {r_q[P-2:0], {SYM_W{1'b0}}};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  assign msb = r_q[P-1];

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS(N,K) encoder over GF(2^5): forwards K message symbols, then appends
// N-K parity symbols highest degree first, behind a single valid/ready output register.
module rs_encoder
  import rs_gf5_pkg::*;
#(
  parameter int unsigned N = N_DEFAULT,
  parameter int unsigned K = K_DEFAULT
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [SYM_W-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [SYM_W-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready
);

  localparam int unsigned P       = N - K;
  localparam int unsigned CNT_W   = 5;
  localparam gen_t        GEN_ALL = gen_poly(P);

  enc_state_e       state_q, state_d;
  logic [CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic             out_valid_q, out_valid_d;
  sym_t             out_data_q, out_data_d;
  logic             out_last_q, out_last_d;

  logic can_load;
  logic accept;
  logic lfsr_feed, lfsr_shift, lfsr_clear;
  sym_t lfsr_msb;

  assign can_load = !out_valid_q || out_ready;
  assign in_ready = (state_q == StMsg) && can_load;
  assign accept   = in_valid && in_ready;

  rs_parity_lfsr #(
    .P   (P),
    .GEN (GEN_ALL[P-1:0])
  ) u_lfsr (
    .clock   (clock),
    .reset_n (reset_n),
    .feed    (lfsr_feed),
    .shift   (lfsr_shift),
    .clear   (lfsr_clear),
    .din     (in_data),
    .msb     (lfsr_msb)
  );

  always_comb begin
    state_d     = state_q;
    sym_cnt_d   = sym_cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    lfsr_feed   = 1'b0;
    lfsr_shift  = 1'b0;
    lfsr_clear  = 1'b0;

    // Drained by downstream; a load below overrides this.
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    unique case (state_q)
      StMsg: begin
        if (accept) begin
          out_valid_d = 1'b1;
          out_data_d  = in_data;
          out_last_d  = 1'b0;
          lfsr_feed   = 1'b1;
          if (sym_cnt_q == CNT_W'(K - 1)) begin
            sym_cnt_d = '0;
            state_d   = StParity;
          end else begin
            sym_cnt_d = sym_cnt_q + 1'b1;
          end
        end
      end
      StParity: begin
        if (can_load) begin
          out_valid_d = 1'b1;
          out_data_d  = lfsr_msb;
          lfsr_shift  = 1'b1;
          if (sym_cnt_q == CNT_W'(P - 1)) begin
            out_last_d = 1'b1;
            sym_cnt_d  = '0;
            lfsr_clear = 1'b1;
            state_d    = StMsg;
          end else begin
            out_last_d = 1'b0;
            sym_cnt_d  = sym_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StMsg;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StMsg;
      sym_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sym_cnt_q   <= sym_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_rs_encoder.sv
// Scoreboard bench for rs_encoder: stimulus queues expected symbols, a monitor pops and
// compares each accepted output and checks codeword syndromes.
module tb_rs_encoder;

  localparam int N = 31;
  localparam int K = 23;
  localparam int P = N - K;

  typedef logic [4:0] sym_t;
  typedef struct packed {
    sym_t data;
    logic last;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  sym_t in_data = '0;
  logic in_ready;
  logic out_valid;
  sym_t out_data;
  logic out_last;
  logic out_ready;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];
  logic [P*5-1:0] cap_q[$];
  sym_t g_tb [P+1];
  sym_t msg_buf [K];
  sym_t par_buf [P];
  sym_t cw [N];
  int sym_idx = 0;
  int rdy_mode = 0;
  bit bp_done = 1'b0;

  rs_encoder #(
    .N (N),
    .K (K)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 clock = ~clock;

  function automatic sym_t gf_mul(sym_t a, sym_t b);
    sym_t p = '0;
    sym_t x = a;
    for (int i = 0; i < 5; i++) begin
      if (b[i]) p = p ^ x;
      x = x[4] ? ({x[3:0], 1'b0} ^ 5'b00101) : {x[3:0], 1'b0};
    end
    return p;
  endfunction

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic build_gen();
    sym_t root = 5'd1;
    for (int i = 0; i <= P; i++) g_tb[i] = '0;
    g_tb[0] = 5'd1;
    for (int i = 1; i <= P; i++) begin
      root = gf_mul(root, 5'd2);
      for (int j = i; j > 0; j--) g_tb[j] = g_tb[j-1] ^ gf_mul(g_tb[j], root);
      g_tb[0] = gf_mul(g_tb[0], root);
    end
  endtask

  // Long division of x^P * m(x) by g(x); msg_buf[0] is the highest-degree message symbol.
  task automatic model_parity();
    sym_t c [N];
    sym_t q;
    for (int i = 0; i < N; i++) c[i] = '0;
    for (int i = 0; i < K; i++) c[N-1-i] = msg_buf[i];
    for (int d = N - 1; d >= P; d--) begin
      q = c[d];
      for (int j = 0; j <= P; j++) c[d-P+j] = c[d-P+j] ^ gf_mul(q, g_tb[j]);
    end
    for (int j = 0; j < P; j++) par_buf[j] = c[j];
  endtask

  task automatic push_expected();
    for (int i = 0; i < K; i++) exp_q.push_back('{data: msg_buf[i], last: 1'b0});
    for (int j = P - 1; j >= 0; j--) exp_q.push_back('{data: par_buf[j], last: (j == 0)});
  endtask

  task automatic put(input sym_t s);
    int t = 0;
    in_valid = 1'b1;
    in_data  = s;
    @(negedge clock);
    while (!in_ready && t < 200) begin
      t++;
      @(negedge clock);
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready timeout: got 0 for 200 cycles, required 1");
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_msg(input int gap_max);
    for (int i = 0; i < K; i++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          @(posedge clock);
          #1;
        end
      end
      put(msg_buf[i]);
    end
  endtask

  task automatic encode(input int gap_max, input bit use_model);
    if (use_model) model_parity();
    push_expected();
    send_msg(gap_max);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      @(posedge clock);
      t++;
    end
    chk("drain pending symbols", exp_q.size(), 0);
    exp_q.delete();
    #1;
  endtask

  task automatic random_msg();
    for (int i = 0; i < K; i++) msg_buf[i] = 5'($urandom_range(0, 31));
  endtask

  // Monitor: compare each accepted output against the scoreboard head.
  initial begin
    exp_t e;
    logic [P*5-1:0] pv;
    sym_t ai, s;
    bit syn_ok;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        sym_idx = 0;
      end else if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected output: got data %02h last %0b, required no output",
                   out_data, out_last);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_last !== e.last) begin
            errors++;
            $display("FAIL symbol %0d: got data %02h last %0b, required data %02h last %0b",
                     sym_idx, out_data, out_last, e.data, e.last);
          end
        end
        if (sym_idx < N) cw[sym_idx] = out_data;
        if (out_last) begin
          syn_ok = (sym_idx == N - 1);
          ai = 5'd1;
          for (int i = 1; i <= P; i++) begin
            ai = gf_mul(ai, 5'd2);
            s = '0;
            for (int k = 0; k < N; k++) s = gf_mul(s, ai) ^ cw[k];
            if (s != 0) syn_ok = 1'b0;
          end
          chk("codeword syndromes zero", int'(syn_ok), 1);
          for (int j = 0; j < P; j++) pv[j*5 +: 5] = cw[N-1-j];
          cap_q.push_back(pv);
          sym_idx = 0;
        end else begin
          sym_idx++;
        end
      end
    end
  end

  // out_ready driver: 0 = always high, 1 = random, 2 = 3-cycle stall at parity symbol 4.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (rdy_mode == 1) begin
        out_ready = ($urandom_range(0, 3) != 0);
      end else if (rdy_mode == 2 && !bp_done && out_valid && sym_idx == K + 3) begin
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(posedge clock);
          #1;
          if (exp_q.size() != 0) begin
            chk("stall out_data hold", out_data, exp_q[0].data);
            chk("stall out_last hold", out_last, exp_q[0].last);
          end
          chk("stall out_valid hold", out_valid, 1);
        end
        out_ready = 1'b1;
        bp_done = 1'b1;
      end else begin
        out_ready = 1'b1;
      end
    end
  end

  initial begin
    sym_t ma [K];
    sym_t mb [K];
    logic [P*5-1:0] pa;
    logic [P*5-1:0] pb;
    logic [P*5-1:0] pc;
    int n0;

    build_gen();
    repeat (3) @(posedge clock);
    #1;
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset out_last", out_last, 0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("in_ready after release", in_ready, 1);
    @(posedge clock);
    #1;

    // All-zero message: every symbol zero, last on symbol 31 only.
    for (int i = 0; i < K; i++) msg_buf[i] = '0;
    for (int j = 0; j < P; j++) par_buf[j] = '0;
    encode(0, 1'b0);

    // Impulse m(x) = 1: parity is x^8 mod g(x), i.e. g0..g7 sent as g7 first.
    for (int i = 0; i < K; i++) msg_buf[i] = '0;
    msg_buf[K-1] = 5'h01;
    par_buf[7] = 5'd8;  par_buf[6] = 5'd21; par_buf[5] = 5'd15; par_buf[4] = 5'd6;
    par_buf[3] = 5'd2;  par_buf[2] = 5'd26; par_buf[1] = 5'd18; par_buf[0] = 5'd5;
    encode(0, 1'b0);
    drain();

    // Linearity: parity(A xor B) = parity(A) xor parity(B).
    n0 = cap_q.size();
    random_msg();
    for (int i = 0; i < K; i++) ma[i] = msg_buf[i];
    encode(0, 1'b1);
    random_msg();
    for (int i = 0; i < K; i++) mb[i] = msg_buf[i];
    encode(0, 1'b1);
    for (int i = 0; i < K; i++) msg_buf[i] = ma[i] ^ mb[i];
    encode(0, 1'b1);
    drain();
    if (cap_q.size() >= n0 + 3) begin
      pa = cap_q[n0];
      pb = cap_q[n0+1];
      pc = cap_q[n0+2];
      checks++;
      if (pc != (pa ^ pb)) begin
        errors++;
        $display("FAIL linearity: got %010h, required %010h", pc, pa ^ pb);
      end
    end else begin
      chk("linearity codewords captured", cap_q.size() - n0, 3);
    end

    // Backpressure at parity symbol 4.
    bp_done = 1'b0;
    rdy_mode = 2;
    random_msg();
    encode(0, 1'b1);
    drain();
    chk("stall exercised", int'(bp_done), 1);
    rdy_mode = 0;

    // Reset after 10 message symbols; partial codeword discarded.
    random_msg();
    for (int i = 0; i < 10; i++) exp_q.push_back('{data: msg_buf[i], last: 1'b0});
    for (int i = 0; i < 10; i++) put(msg_buf[i]);
    @(negedge clock);
    #2;
    chk("partial symbols emitted", exp_q.size(), 0);
    reset_n = 1'b0;
    #1;
    chk("mid reset out_valid", out_valid, 0);
    chk("mid reset out_data", out_data, 0);
    chk("mid reset out_last", out_last, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("in_ready after mid reset", in_ready, 1);
    @(posedge clock);
    #1;
    random_msg();
    encode(0, 1'b1);
    drain();

    // Random messages with gaps and random out_ready.
    rdy_mode = 1;
    for (int n = 0; n < 4; n++) begin
      random_msg();
      encode(2, 1'b1);
    end
    drain();
    rdy_mode = 0;
    repeat (3) @(posedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
